wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 24 ++
 rtl/dff.sv | 20 ++
 rtl/wb_regfile_pend_ctr.sv | 44 ++++
 rtl/wb_regfile.sv | 83 ++++++++
 tb/tb_wb_regfile.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared sizing constants and helpers for the write-back register file.
//   RF_DATA_W   : default register data width
//   RF_N_REGS   : default register count
//   RF_SEL_W    : register select width
//   RF_PEND_W   : per-register pending-write counter width
package wb_regfile_pkg;

  localparam int unsigned RF_DATA_W = 16;
  localparam int unsigned RF_N_REGS = 8;
  localparam int unsigned RF_SEL_W  = 3;
  localparam int unsigned RF_PEND_W = 2;

  localparam logic [RF_PEND_W-1:0] RF_PEND_MAX = '1;

  // A read must wait while more than one write is outstanding, or while the
  // single outstanding write is not arriving this cycle to be bypassed.
  function automatic logic operand_blocked(input logic                 rd_en,
                                           input logic [RF_PEND_W-1:0] pend,
                                           input logic                 wr_hit);
    return rd_en && ((pend >= RF_PEND_W'(2)) ||
                     ((pend == RF_PEND_W'(1)) && !wr_hit));
  endfunction

endpackage

// File: rtl/dff.sv
// Generic W-bit D flip-flop with asynchronous active-high clear.
//   i_clk : clock, rising edge
//   i_rst : asynchronous clear to zero
//   i_d   : next value
//   o_q   : registered value
module dff #(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_q <= '0;
    else       o_q <= i_d;
  end

endmodule

// File: rtl/wb_regfile_pend_ctr.sv
// Saturating up/down pending-write counter for one register.
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous clear
//   i_inc   : an instruction writing this register was issued
//   i_dec   : a write-back to this register completed
//   o_count : current pending count
//   o_err_c : combinational; this cycle attempts overflow or underflow
module pend_ctr
  import wb_regfile_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_inc,
  input  logic                 i_dec,
  output logic [RF_PEND_W-1:0] o_count,
  output logic                 o_err_c
);

  logic [RF_PEND_W-1:0] r_count;
  logic [RF_PEND_W-1:0] w_count_nxt;

  // Simultaneous inc and dec cancel; saturating ends hold and flag an error.
  always_comb begin
    w_count_nxt = r_count;
    o_err_c     = 1'b0;
    if (i_inc && !i_dec) begin
      if (r_count == RF_PEND_MAX) o_err_c = 1'b1;
      else                        w_count_nxt = r_count + RF_PEND_W'(1);
    end else if (i_dec && !i_inc) begin
      if (r_count == '0) o_err_c = 1'b1;
      else               w_count_nxt = r_count - RF_PEND_W'(1);
    end
  end

  dff #(.W(RF_PEND_W)) u_count (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (w_count_nxt),
    .o_q   (r_count)
  );

  assign o_count = r_count;

endmodule

// File: rtl/wb_regfile.sv
// Register file with write-back bypass and a pending-write scoreboard.
//   clk, rst                 : clock (rising edge), async active-high reset
//   writeEn/RegSel/Data      : write-back port
//   read1En/RegSel, read2En/RegSel : combinational read ports
//   issueEn/RegSel           : decode marks a register as having a write in flight
//   read1Data, read2Data     : read data, bypassed from writeData on a match
//   stall                    : combinational; a requested operand is not ready
//   err                      : sticky scoreboard overflow/underflow
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned N_REGS = RF_N_REGS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                writeEn,
  input  logic [RF_SEL_W-1:0] writeRegSel,
  input  logic [DATA_W-1:0]   writeData,
  input  logic                read1En,
  input  logic [RF_SEL_W-1:0] read1RegSel,
  input  logic                read2En,
  input  logic [RF_SEL_W-1:0] read2RegSel,
  input  logic                issueEn,
  input  logic [RF_SEL_W-1:0] issueRegSel,
  output logic [DATA_W-1:0]   read1Data,
  output logic [DATA_W-1:0]   read2Data,
  output logic                stall,
  output logic                err
);

  logic [DATA_W-1:0]    w_q    [N_REGS];
  logic [RF_PEND_W-1:0] w_pend [N_REGS];
  logic [N_REGS-1:0]    w_ctr_err;
  logic                 r_err;
  logic                 w_byp1;
  logic                 w_byp2;

  // Per-register storage and scoreboard counter.
  for (genvar g = 0; g < N_REGS; g++) begin : g_reg
    logic w_wr_hit;
    logic w_iss_hit;

    assign w_wr_hit  = writeEn && (writeRegSel == RF_SEL_W'(g));
    assign w_iss_hit = issueEn && (issueRegSel == RF_SEL_W'(g));

    dff #(.W(DATA_W)) u_data (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (w_wr_hit ? writeData : w_q[g]),
      .o_q   (w_q[g])
    );

    pend_ctr u_pend (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_inc   (w_iss_hit),
      .i_dec   (w_wr_hit),
      .o_count (w_pend[g]),
      .o_err_c (w_ctr_err[g])
    );
  end

  // Sticky error: any counter saturation event latches until reset.
  dff #(.W(1)) u_err (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (r_err | (|w_ctr_err)),
    .o_q   (r_err)
  );

  assign err = r_err;

  assign w_byp1 = writeEn && (writeRegSel == read1RegSel);
  assign w_byp2 = writeEn && (writeRegSel == read2RegSel);

  assign read1Data = w_byp1 ? writeData : w_q[read1RegSel];
  assign read2Data = w_byp2 ? writeData : w_q[read2RegSel];

  assign stall = operand_blocked(read1En, w_pend[read1RegSel], w_byp1) ||
                 operand_blocked(read2En, w_pend[read2RegSel], w_byp2);

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        writeEn;
  logic [2:0]  writeRegSel;
  logic [15:0] writeData;
  logic        read1En;
  logic [2:0]  read1RegSel;
  logic        read2En;
  logic [2:0]  read2RegSel;
  logic        issueEn;
  logic [2:0]  issueRegSel;
  logic [15:0] read1Data;
  logic [15:0] read2Data;
  logic        stall;
  logic        err;

  int n_cmp = 0;
  int n_mis = 0;

  wb_regfile #(.DATA_W(16), .N_REGS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .writeEn     (writeEn),
    .writeRegSel (writeRegSel),
    .writeData   (writeData),
    .read1En     (read1En),
    .read1RegSel (read1RegSel),
    .read2En     (read2En),
    .read2RegSel (read2RegSel),
    .issueEn     (issueEn),
    .issueRegSel (issueRegSel),
    .read1Data   (read1Data),
    .read2Data   (read2Data),
    .stall       (stall),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    writeEn = 1'b0; read1En = 1'b0; read2En = 1'b0; issueEn = 1'b0;
  endtask

  task automatic issue(input logic [2:0] sel);
    issueEn = 1'b1; issueRegSel = sel;
    tick();
    issueEn = 1'b0;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [15:0] d);
    writeEn = 1'b1; writeRegSel = sel; writeData = d;
    tick();
    writeEn = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    writeRegSel = 3'd0; writeData = 16'h0; read1RegSel = 3'd0;
    read2RegSel = 3'd0; issueRegSel = 3'd0;

    // Reset state, with bypass still active on port 1.
    writeEn = 1'b1; writeRegSel = 3'd0; writeData = 16'h0077;
    read1RegSel = 3'd0; read2RegSel = 3'd1;
    #2;
    chk("rst_byp_rd1", 32'(read1Data), 32'h0077);
    chk("rst_rd2",     32'(read2Data), 32'h0000);
    chk("rst_stall",   32'(stall),     32'h0);
    chk("rst_err",     32'(err),       32'h0);
    writeEn = 1'b0;
    tick();
    rst = 1'b0;

    // Scenario 1: plain write/read and same-cycle bypass.
    issue(3'd3);
    issue(3'd5);
    wr(3'd3, 16'h1234);
    read1RegSel = 3'd3;
    settle();
    chk("r3_rd", 32'(read1Data), 32'h1234);
    writeEn = 1'b1; writeRegSel = 3'd5; writeData = 16'hBEEF;
    read2En = 1'b1; read2RegSel = 3'd5;
    settle();
    chk("r5_byp",       32'(read2Data), 32'hBEEF);
    chk("r5_byp_stall", 32'(stall),     32'h0);
    tick();
    writeEn = 1'b0; read2En = 1'b0;
    settle();
    chk("r5_rd",  32'(read2Data), 32'hBEEF);
    chk("s1_err", 32'(err),       32'h0);

    // Scenario 2: one pending write, stall until it arrives.
    issue(3'd2);
    read1En = 1'b1; read1RegSel = 3'd2;
    settle();
    chk("r2_stall", 32'(stall), 32'h1);
    read1En = 1'b0;
    settle();
    chk("r2_noen", 32'(stall), 32'h0);
    read2En = 1'b1; read2RegSel = 3'd2;
    settle();
    chk("r2_port2", 32'(stall), 32'h1);
    read2En = 1'b0;
    tick();
    read1En = 1'b1; read1RegSel = 3'd2;
    writeEn = 1'b1; writeRegSel = 3'd2; writeData = 16'h00AA;
    settle();
    chk("r2_wb_stall", 32'(stall),     32'h0);
    chk("r2_wb_data",  32'(read1Data), 32'h00AA);
    tick();
    writeEn = 1'b0;
    settle();
    chk("r2_after_stall", 32'(stall),     32'h0);
    chk("r2_after_data",  32'(read1Data), 32'h00AA);
    read1En = 1'b0;

    // Scenario 3: two pending writes to R4.
    issue(3'd4);
    issue(3'd4);
    read1En = 1'b1; read1RegSel = 3'd4;
    writeEn = 1'b1; writeRegSel = 3'd4; writeData = 16'h0044;
    settle();
    chk("r4_p2_wb_stall", 32'(stall), 32'h1);
    tick();
    writeEn = 1'b0;
    settle();
    chk("r4_p1_stall", 32'(stall), 32'h1);
    writeEn = 1'b1; writeRegSel = 3'd4; writeData = 16'h0045;
    settle();
    chk("r4_p1_wb_stall", 32'(stall), 32'h0);
    tick();
    writeEn = 1'b0;
    settle();
    chk("r4_p0_stall", 32'(stall),     32'h0);
    chk("r4_p0_data",  32'(read1Data), 32'h0045);
    read1En = 1'b0;

    // Scenario 4: issue and write R6 together keeps pend at 1.
    issue(3'd6);
    issueEn = 1'b1; issueRegSel = 3'd6;
    writeEn = 1'b1; writeRegSel = 3'd6; writeData = 16'h0666;
    tick();
    idle();
    read2En = 1'b1; read2RegSel = 3'd6;
    settle();
    chk("r6_same_stall", 32'(stall),     32'h1);
    chk("r6_same_data",  32'(read2Data), 32'h0666);
    chk("r6_same_err",   32'(err),       32'h0);
    read2En = 1'b0;
    // Issue R0 and write R6 together: both counters move.
    issueEn = 1'b1; issueRegSel = 3'd0;
    writeEn = 1'b1; writeRegSel = 3'd6; writeData = 16'h0667;
    tick();
    idle();
    read2En = 1'b1; read2RegSel = 3'd6;
    settle();
    chk("r6_cleared_stall", 32'(stall), 32'h0);
    read2RegSel = 3'd0;
    settle();
    chk("r0_pending_stall", 32'(stall), 32'h1);
    read2En = 1'b0;
    wr(3'd0, 16'h0100);
    chk("pre_ovf_err", 32'(err), 32'h0);

    // Scenario 5a: overflow on R7.
    issue(3'd7);
    issue(3'd7);
    issue(3'd7);
    chk("r7_p3_err", 32'(err), 32'h0);
    issue(3'd7);
    chk("r7_ovf_err", 32'(err), 32'h1);
    wr(3'd7, 16'h0007);
    wr(3'd7, 16'h0007);
    read1En = 1'b1; read1RegSel = 3'd7;
    settle();
    chk("r7_sat_pend1", 32'(stall), 32'h1);
    read1En = 1'b0;
    wr(3'd7, 16'h0007);
    read1En = 1'b1;
    settle();
    chk("r7_sat_pend0", 32'(stall), 32'h0);
    read1En = 1'b0;

    // Clear err, then scenario 5b: underflow on R1.
    rst = 1'b1;
    settle();
    chk("rst_err_clr", 32'(err), 32'h0);
    tick();
    rst = 1'b0;
    wr(3'd1, 16'h0011);
    chk("r1_uflow_err", 32'(err), 32'h1);
    read1En = 1'b1; read1RegSel = 3'd1;
    settle();
    chk("r1_uflow_pend0", 32'(stall),     32'h0);
    chk("r1_uflow_data",  32'(read1Data), 32'h0011);
    read1En = 1'b0;
    tick();
    chk("err_sticky", 32'(err), 32'h1);

    // Scenario 6: async reset mid-cycle with pend[2]=2, R2=0x5555.
    issue(3'd2);
    issue(3'd2);
    issue(3'd2);
    wr(3'd2, 16'h5555);
    read1En = 1'b1; read1RegSel = 3'd2;
    read2En = 1'b1; read2RegSel = 3'd2;
    settle();
    chk("r2_pre_rst_stall", 32'(stall),     32'h1);
    chk("r2_pre_rst_data",  32'(read1Data), 32'h5555);
    rst = 1'b1;
    settle();
    chk("arst_rd1",   32'(read1Data), 32'h0000);
    chk("arst_rd2",   32'(read2Data), 32'h0000);
    chk("arst_stall", 32'(stall),     32'h0);
    chk("arst_err",   32'(err),       32'h0);
    tick();
    rst = 1'b0;
    read2En = 1'b0;
    issueEn = 1'b1; issueRegSel = 3'd2;
    settle();
    chk("post_rst_idle_stall", 32'(stall), 32'h0);
    tick();
    issueEn = 1'b0;
    settle();
    chk("post_rst_issue_stall", 32'(stall), 32'h1);
    writeEn = 1'b1; writeRegSel = 3'd2; writeData = 16'h0022;
    settle();
    chk("post_rst_byp_stall", 32'(stall),     32'h0);
    chk("post_rst_byp_data",  32'(read1Data), 32'h0022);
    tick();
    writeEn = 1'b0;
    settle();
    chk("post_rst_data",  32'(read1Data), 32'h0022);
    chk("post_rst_stall", 32'(stall),     32'h0);
    chk("post_rst_err",   32'(err),       32'h0);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
